lfsr_gen: RTL
=============

# lfsr_gen

Parametrised, steppable linear-feedback shift register generating pseudo-random words for the lab datapaths. It supersedes the fixed 8-bit many-to-one LFSR. It adds generic width and polynomial, a run-time choice between many-to-one (Fibonacci) and one-to-many (Galois) feedback, step enable, and seed load. It also has a period-wrap detector. It sits wherever a test pattern, scrambler or random source is needed and is clocked by the system clock.

## Interface
- WIDTH, 8, register width; legal 3..32
- POLY, 8'h71, feedback polynomial coefficients of x^0..x^(WIDTH-1); x^WIDTH is implicit; POLY[0] must be 1
- SEED, 8'hBD, reset value of `out`; must be non-zero
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  advance the register one step this cycle
- mode  input  1  0 = many-to-one (Fibonacci), 1 = one-to-many (Galois)
- load  input  1  load `seed_in` this cycle; has priority over `en`
- seed_in  input  WIDTH  value to load
- out  output  WIDTH  current register state
- wrap  output  1  one-cycle pulse: a step has just returned `out` to the start value

## Operation
- Reset (rst_n low, asynchronous): `out` = SEED, start register = SEED, `wrap` = 0.
- Priority each rising edge: load, then en, then hold.
- Load:
  - `out` ← seed_in; start register ← seed_in; `wrap` ← 0.
- Step, mode 0 (Fibonacci):
  - Feedback f = XOR of out[WIDTH-1-i] over all i with POLY[i]=1.
  - `out` ← {out[WIDTH-2:0], f}.
  - Default case: f = out[7]^out[3]^out[2]^out[1].
- Step, mode 1 (Galois):
  - m = out[WIDTH-1].
  - next[0] = m & POLY[0].
  - next[i] = out[i-1] ^ (m & POLY[i]) for i = 1..WIDTH-1.
- Wrap:
  - `wrap` ← 1 when a step produces a next state equal to the start register; otherwise `wrap` ← 0.
  - Hold cycles drive `wrap` ← 0.
- `mode` is sampled every step. Switching modes mid-sequence is legal. The start register is unchanged, so `wrap` fires only if the new trajectory reaches it.
- The all-zero state is a lock-up state under both modes. Handling depends on the configuration macro.

## Timing
- All state updates occur on the rising edge of `clk`; `out` and `wrap` are registered.
- Latency from `en` high at an edge to the new `out`: 1 cycle.
- Latency from `load` to `out` = seed_in: 1 cycle.
- `wrap` is high in the same cycle that `out` first shows the returning start value, for exactly one cycle.
- With a primitive POLY and `en` held high, `wrap` pulses every 2^WIDTH−1 cycles.
- Asserting rst_n low mid-run restores the reset values immediately, without waiting for a clock edge. The first step occurs at the first rising edge after rst_n is high.
- `load` and `en` asserted together: the load wins, no step occurs, and `wrap` = 0.

## Configuration
- `LFSR_LOCKUP_GUARD_EN` defined:
  - A load of all zeros stores SEED in both `out` and the start register.
  - If `out` is ever zero at a step edge, the step produces SEED.
- `LFSR_LOCKUP_GUARD_EN` undefined:
  - A zero load is stored as-is and `out` stays 0 on every step.
  - `wrap` pulses on every step, because next state equals start (0).

## Test plan
- Reset, then one step in mode 0 (defaults) -> `out` goes 0xBD -> 0x7B; `wrap` = 0.
- Reset, then one step in mode 1 -> `out` goes 0xBD -> 0x0B.
- Reset, en held 255 cycles in mode 0, repeated in mode 1 -> `out` returns to 0xBD at step 255, with `wrap` high for only that cycle. No earlier repeat of any value; 255 distinct states seen.
- Load 0x01 with en also high, then 255 steps -> load wins, `out` = 0x01; `wrap` pulses at step 255 with `out` = 0x01.
- Load 0x00:
  - With the macro defined -> `out` = 0xBD, and stepping proceeds normally.
  - With the macro undefined -> `out` stays 0x00 and `wrap` pulses every step.
- Pull rst_n low mid-run, between clock edges -> `out` = 0xBD and `wrap` = 0 immediately. The sequence restarts from 0xBD after release.

Source files
------------

// File: rtl/lfsr_gen_if.sv
// Handshake bundle for lfsr_gen: step/load controls in, register state and wrap pulse out.
interface lfsr_gen_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] seed_in;
    logic [WIDTH-1:0] out;
    logic             wrap;

    modport master (
        output en,
        output mode,
        output load,
        output seed_in,
        input  out,
        input  wrap
    );

    modport slave (
        input  en,
        input  mode,
        input  load,
        input  seed_in,
        output out,
        output wrap
    );
endinterface

// File: rtl/lfsr_gen.sv
// Steppable LFSR with run-time Fibonacci/Galois feedback, seed load and period-wrap pulse.
// Optional feature: define LFSR_LOCKUP_GUARD_EN to replace the all-zero state with SEED.
module lfsr_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'h71,
    parameter logic [WIDTH-1:0] SEED  = 8'hBD
) (
    input  logic      clk,
    input  logic      rst_n,
    lfsr_gen_if.slave bus
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] start_d;
    logic             wrap_q;
    logic             wrap_d;

    logic [WIDTH-1:0] fib_terms;
    logic             fib_fb;
    logic [WIDTH-1:0] fib_next;
    logic [WIDTH-1:0] gal_next;
    logic             gal_msb;
    logic [WIDTH-1:0] raw_next;
    logic [WIDTH-1:0] step_next;
    logic [WIDTH-1:0] load_val;

    assign gal_msb = out_q[WIDTH-1];

    // POLY bit i taps out[WIDTH-1-i] in Fibonacci form and injects into bit i in Galois form.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_taps
            assign fib_terms[gi] = POLY[gi] & out_q[WIDTH-1-gi];
            if (gi == 0) begin : g_lsb
                assign gal_next[gi] = gal_msb & POLY[gi];
            end else begin : g_upper
                assign gal_next[gi] = out_q[gi-1] ^ (gal_msb & POLY[gi]);
            end
        end
    endgenerate

    assign fib_fb   = ^fib_terms;
    assign fib_next = {out_q[WIDTH-2:0], fib_fb};
    assign raw_next = bus.mode ? gal_next : fib_next;

`ifdef LFSR_LOCKUP_GUARD_EN
    // Zero can never be entered, so substitute SEED wherever it would appear.
    assign load_val  = (bus.seed_in == '0) ? SEED : bus.seed_in;
    assign step_next = (out_q == '0) ? SEED : raw_next;
`else
    assign load_val  = bus.seed_in;
    assign step_next = raw_next;
`endif

    always_comb begin
        out_d   = out_q;
        start_d = start_q;
        wrap_d  = 1'b0;
        if (bus.load) begin
            out_d   = load_val;
            start_d = load_val;
        end else if (bus.en) begin
            out_d  = step_next;
            wrap_d = (step_next == start_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= SEED;
            start_q <= SEED;
            wrap_q  <= 1'b0;
        end else begin
            out_q   <= out_d;
            start_q <= start_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.wrap = wrap_q;

endmodule
